pulse_generator_multi: RTL and testbench
========================================

// Module: pulse_generator_multi
// PURPOSE
//  NUM_CH independent pulse channels, each with runtime-programmable period, high time and burst count.
//  Successor to the fixed-ratio MHz pulse generators: arbitrary duty cycle, finite bursts,
//  glitch-free reconfiguration at period boundaries, and a common sync restart.
//  Sits between the control/register front end and the output pins; runs on the 100 MHz system clock.
// PARAMETERS
//  NUM_CH   4   number of channels (1..16)
//  CNT_W    16  width of period/high counters, in clk cycles
//  BURST_W  8   width of burst count; 0 = continuous
//  CH_W     localparam, max(1,$clog2(NUM_CH))
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous reset, active-low
//  cfg_we       in   1        write cfg_* into shadow regs of channel cfg_ch
//  cfg_ch       in   CH_W     target channel; cfg_ch >= NUM_CH: write ignored
//  cfg_period   in   CNT_W    period in clk cycles
//  cfg_high     in   CNT_W    high cycles per period
//  cfg_burst    in   BURST_W  periods per burst; 0 = run until disabled
//  enable       in   NUM_CH   per-channel run request, level
//  sync_start   in   1        one-cycle pulse: restart all RUN channels at phase 0
//  pulse_out    out  NUM_CH   registered pulse outputs
//  active       out  NUM_CH   channel in RUN
//  burst_done   out  NUM_CH   one-cycle strobe on completion of a finite burst
// BEHAVIOUR
//  Reset:
//   - All outputs, counters and active regs = 0. FSM = IDLE.
//   - Shadow regs reset to period=20, high=10, burst=0.
//  Shadow regs:
//   - Written on the cfg_we edge. Never affect a running period.
//  Active regs:
//   - Copied from shadow on IDLE->RUN, on every wrap (counter==period_a-1), and on sync_start.
//   - A write on the same edge as a wrap takes effect at the following wrap.
//  Clamping, applied on load:
//   - period < 2 -> 2.
//   - high >= period -> constant 1.
//   - high == 0 -> constant 0.
//  Per-channel FSM:
//   - IDLE: counter=0, pulse_out=0. On enable=1 -> load active, counter<=0, cnt_periods<=0, go RUN.
//   - RUN, each edge:
//     - pulse_out <= (counter < high_a).
//     - counter <= (counter==period_a-1) ? 0 : counter+1.
//     - On a wrap, cnt_periods++.
//     - If burst_a!=0 and a wrap completes period burst_a -> go HOLD, burst_done=1 for one cycle.
//   - HOLD: pulse_out=0, waits for enable=0 -> IDLE. Re-arm requires enable low then high.
//   - enable=0 in any state: next edge -> IDLE, pulse_out=0, counter=0, no burst_done.
//   - sync_start in RUN: counter<=0, cnt_periods<=0, active reload. Same pulse_out rule applies that edge.
//     sync_start has no effect in IDLE/HOLD.
//  Latency:
//   - Enable sampled at edge E -> first pulse_out high after edge E+1 (if high_a>0).
//   - active=1 after edge E.
//  Output duty:
//   - Exactly high_a of every period_a cycles.
//   - Output period exactly period_a cycles; no drift, no truncated period on reconfiguration.
//  Channels:
//   - Fully independent except for the shared cfg port and sync_start.
//   - Simultaneous enable of several channels gives identical phase.
// STRUCTURE
//  Package pulse_gen_pkg:
//   - FSM state encoding (IDLE/RUN/HOLD).
//   - Reset shadow defaults.
//   - Min period constant (2).
//  Sub-module pulse_channel: one channel (shadow, active regs, counter, FSM).
//   - Instantiated NUM_CH times in a generate loop.
//   - Top level only decodes cfg_ch into per-channel write enables.
// TESTING
//  - Reset defaults: enable[0]=1, no cfg -> period 20, 10 high; first high after edge E+1; burst_done never.
//  - cfg ch1 period=5 high=2 burst=2, enable[1] at E
//    -> high after E+1, E+2, E+6, E+7; burst_done[1] after E+10 only; then 0 in HOLD until enable toggled.
//  - Running period=8 high=4; write high=6 mid-period
//    -> current period stays 4/8; next period 6/8; no glitch.
//  - Clamp cases:
//    - period=1 high=1 -> constant 1 (period 2).
//    - high=0 -> pulse_out stays 0.
//    - high=9 period=8 -> constant 1.
//  - ch0, ch2 running with different phases; sync_start
//    -> both counters 0 same edge; edges aligned after; ch3 in IDLE unaffected.
//  - Reset asserted mid-RUN and enable dropped mid-burst
//    -> outputs 0 immediately / next edge; no burst_done; cfg_ch=NUM_CH write ignored.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared constants for the multi-channel pulse generator: FSM encoding,
// power-on shadow configuration and the shortest legal period.
package pulse_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam int DEF_PERIOD = 20;
   localparam int DEF_HIGH   = 10;
   localparam int DEF_BURST  = 0;
   localparam int MIN_PERIOD = 2;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: shadow config, active (clamped) config, phase counter
// and the IDLE/RUN/HOLD sequencer.
module pulse_channel
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_cfg_we,
   input  logic [CNT_W-1:0]   i_cfg_period,
   input  logic [CNT_W-1:0]   i_cfg_high,
   input  logic [BURST_W-1:0] i_cfg_burst,
   input  logic               i_enable,
   input  logic               i_sync_start,
   output logic               o_pulse,
   output logic               o_active,
   output logic               o_burst_done
);

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_period_s, r_high_s;
   logic [BURST_W-1:0] r_burst_s;
   logic [CNT_W-1:0]   r_period_a, r_high_a;
   logic [BURST_W-1:0] r_burst_a;
   logic [CNT_W-1:0]   r_counter;
   logic [BURST_W-1:0] r_cnt_periods;
   logic               r_pulse;
   logic               r_burst_done;

   logic [CNT_W-1:0]   w_period_ld, w_high_ld;
   logic               w_wrap, w_last;

   // High time is clamped against the raw period so that period=1/high=1
   // still means "always high" after the period is widened to the minimum.
   assign w_period_ld = (r_period_s < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : r_period_s;
   assign w_high_ld   = (r_high_s == '0)        ? '0 :
                        (r_high_s >= r_period_s) ? w_period_ld : r_high_s;

   assign w_wrap = (r_counter == r_period_a - CNT_W'(1));
   assign w_last = (r_burst_a != '0) && (r_cnt_periods == r_burst_a - BURST_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_period_s    <= CNT_W'(DEF_PERIOD);
         r_high_s      <= CNT_W'(DEF_HIGH);
         r_burst_s     <= BURST_W'(DEF_BURST);
         r_period_a    <= '0;
         r_high_a      <= '0;
         r_burst_a     <= '0;
         r_counter     <= '0;
         r_cnt_periods <= '0;
         r_pulse       <= 1'b0;
         r_burst_done  <= 1'b0;
      end else begin
         if (i_cfg_we) begin
            r_period_s <= i_cfg_period;
            r_high_s   <= i_cfg_high;
            r_burst_s  <= i_cfg_burst;
         end
         r_burst_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_pulse   <= 1'b0;
               r_counter <= '0;
               if (i_enable) begin
                  r_period_a    <= w_period_ld;
                  r_high_a      <= w_high_ld;
                  r_burst_a     <= r_burst_s;
                  r_cnt_periods <= '0;
                  r_state       <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!i_enable) begin
                  r_pulse   <= 1'b0;
                  r_counter <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_pulse <= (r_counter < r_high_a);
                  if (i_sync_start || w_wrap) begin
                     r_counter  <= '0;
                     r_period_a <= w_period_ld;
                     r_high_a   <= w_high_ld;
                     r_burst_a  <= r_burst_s;
                  end else begin
                     r_counter <= r_counter + CNT_W'(1);
                  end
                  if (i_sync_start) begin
                     r_cnt_periods <= '0;
                  end else if (w_wrap) begin
                     r_cnt_periods <= r_cnt_periods + BURST_W'(1);
                     if (w_last) begin
                        r_state      <= ST_HOLD;
                        r_burst_done <= 1'b1;
                     end
                  end
               end
            end
            ST_HOLD: begin
               r_pulse   <= 1'b0;
               r_counter <= '0;
               if (!i_enable) r_state <= ST_IDLE;
            end
            default: begin
               r_pulse   <= 1'b0;
               r_counter <= '0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_pulse      = r_pulse;
   assign o_active     = (r_state == ST_RUN);
   assign o_burst_done = r_burst_done;

endmodule

// File: rtl/pulse_generator_multi.sv
// NUM_CH independent pulse channels sharing one config port and a common
// sync restart; the top only steers config writes to the addressed channel.
module pulse_generator_multi
   import pulse_gen_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int CNT_W   = 16,
   parameter  int BURST_W = 8,
   localparam int CH_W    = ch_w(NUM_CH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [CNT_W-1:0]   cfg_high,
   input  logic [BURST_W-1:0] cfg_burst,
   input  logic [NUM_CH-1:0]  enable,
   input  logic               sync_start,
   output logic [NUM_CH-1:0]  pulse_out,
   output logic [NUM_CH-1:0]  active,
   output logic [NUM_CH-1:0]  burst_done
);

   logic [NUM_CH-1:0] w_we;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         // Addresses at or above NUM_CH match no channel and are dropped.
         assign w_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

         pulse_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
         ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_cfg_we     (w_we[gi]),
            .i_cfg_period (cfg_period),
            .i_cfg_high   (cfg_high),
            .i_cfg_burst  (cfg_burst),
            .i_enable     (enable[gi]),
            .i_sync_start (sync_start),
            .o_pulse      (pulse_out[gi]),
            .o_active     (active[gi]),
            .o_burst_done (burst_done[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pulse_generator_multi.sv
// Directed bench: stimulus pushes per-cycle expected channel outputs into a
// scoreboard; a negedge monitor pops and compares entries due that cycle.
module tb_pulse_generator_multi;

   localparam int NUM_CH  = 5;
   localparam int CNT_W   = 16;
   localparam int BURST_W = 8;
   localparam int CH_W    = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cfg_we;
   logic [CH_W-1:0]    cfg_ch;
   logic [CNT_W-1:0]   cfg_period;
   logic [CNT_W-1:0]   cfg_high;
   logic [BURST_W-1:0] cfg_burst;
   logic [NUM_CH-1:0]  enable;
   logic               sync_start;
   logic [NUM_CH-1:0]  pulse_out;
   logic [NUM_CH-1:0]  active;
   logic [NUM_CH-1:0]  burst_done;

   pulse_generator_multi #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_burst  (cfg_burst),
      .enable     (enable),
      .sync_start (sync_start),
      .pulse_out  (pulse_out),
      .active     (active),
      .burst_done (burst_done)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int   cyc;
      int   ch;
      logic p;
      logic a;
      logic d;
      int   tid;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic [2:0] mon_got, mon_exp;

   always @(negedge clk) begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].cyc == edge_cnt) begin
            mon_got = {pulse_out[sb[k].ch], active[sb[k].ch], burst_done[sb[k].ch]};
            mon_exp = {sb[k].p, sb[k].a, sb[k].d};
            checks++;
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL chan_out test=%0d cyc=%0d ch=%0d pulse/active/done got=%b required=%b",
                        sb[k].tid, edge_cnt, sb[k].ch, mon_got, mon_exp);
            end
            sb.delete(k);
         end
      end
   end

   task automatic push(input int cyc, input int ch, input logic p, input logic a,
                       input logic d, input int tid);
      exp_t e;
      e.cyc = cyc; e.ch = ch; e.p = p; e.a = a; e.d = d; e.tid = tid;
      sb.push_back(e);
   endtask

   // Running channel: after edge base+1+i the output reflects phase i.
   task automatic exp_run(input int ch, input int base, input int from_i, input int to_i,
                          input int per, input int hi, input int tid);
      for (int i = from_i; i <= to_i; i++)
         push(base + 1 + i, ch, ((i % per) < hi), 1'b1, 1'b0, tid);
   endtask

   task automatic exp_idle(input int ch, input int c0, input int c1, input int tid);
      for (int c = c0; c <= c1; c++) push(c, ch, 1'b0, 1'b0, 1'b0, tid);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int ch, input int p, input int h, input int b);
      cfg_ch     = CH_W'(ch);
      cfg_period = CNT_W'(p);
      cfg_high   = CNT_W'(h);
      cfg_burst  = BURST_W'(b);
      cfg_we     = 1'b1;
      $display("cfg   edge=%0d ch=%0d period=%0d high=%0d burst=%0d", edge_cnt + 1, ch, p, h, b);
      tick(1);
      cfg_we = 1'b0;
   endtask

   task automatic start_ch(input int ch, input int tid, output int e);
      e = edge_cnt + 1;
      enable[ch] = 1'b1;
      push(e, ch, 1'b0, 1'b1, 1'b0, tid);
      $display("start edge=%0d ch=%0d", e, ch);
   endtask

   task automatic stop_ch(input int ch, input int tid);
      push(edge_cnt + 1, ch, 1'b0, 1'b0, 1'b0, tid);
      enable[ch] = 1'b0;
      $display("stop  edge=%0d ch=%0d", edge_cnt + 1, ch);
   endtask

   int e, e2, s, k;
   int clamp_p[3] = '{1, 10, 8};
   int clamp_h[3] = '{1, 0, 9};
   int clamp_x[3] = '{2, 10, 8};
   int clamp_y[3] = '{2, 0, 8};

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
      cfg_burst = '0; enable = '0; sync_start = 1'b0;

      // Reset state
      for (int ch = 0; ch < NUM_CH; ch++) exp_idle(ch, 1, 3, 0);
      tick(3);
      rst_n = 1'b1;
      $display("reset released edge=%0d", edge_cnt);
      tick(1);

      checks++;
      if (pulse_out !== '0) begin
         errors++;
         $display("FAIL post_reset pulse_out got=%b required=0", pulse_out);
      end
      checks++;
      if (active !== '0) begin
         errors++;
         $display("FAIL post_reset active got=%b required=0", active);
      end
      checks++;
      if (burst_done !== '0) begin
         errors++;
         $display("FAIL post_reset burst_done got=%b required=0", burst_done);
      end

      // Power-on shadow defaults: 20-cycle period, 10 high, continuous
      start_ch(0, 1, e);
      exp_run(0, e, 0, 44, 20, 10, 1);
      tick(46);
      stop_ch(0, 1);
      tick(2);

      // Finite burst of two 5/2 periods, hold, then re-arm
      cfg_write(1, 5, 2, 2);
      start_ch(1, 2, e);
      exp_run(1, e, 0, 8, 5, 2, 2);
      push(e + 10, 1, 1'b0, 1'b0, 1'b1, 2);
      exp_idle(1, e + 11, e + 16, 2);
      tick(17);
      stop_ch(1, 2);
      tick(1);
      start_ch(1, 2, e2);
      exp_run(1, e2, 0, 8, 5, 2, 2);
      push(e2 + 10, 1, 1'b0, 1'b0, 1'b1, 2);
      tick(11);
      stop_ch(1, 2);
      tick(2);

      // Mid-period rewrite, then a rewrite landing exactly on a wrap edge
      cfg_write(2, 8, 4, 0);
      start_ch(2, 3, e);
      for (int i = 0; i < 32; i++)
         push(e + 1 + i, 2, ((i % 8) < ((i < 8) ? 4 : (i < 24) ? 6 : 2)), 1'b1, 1'b0, 3);
      tick(3);
      cfg_write(2, 8, 6, 0);
      tick(12);
      cfg_write(2, 8, 2, 0);
      tick(17);
      stop_ch(2, 3);
      tick(2);

      // Clamping cases on channel 3
      for (int t = 0; t < 3; t++) begin
         cfg_write(3, clamp_p[t], clamp_h[t], 0);
         start_ch(3, 4 + t, e);
         exp_run(3, e, 0, 7, clamp_x[t], clamp_y[t], 4 + t);
         tick(9);
         stop_ch(3, 4 + t);
         tick(2);
      end

      // Ignored write to a non-existent channel, simultaneous start, sync restart
      cfg_write(2, 7, 3, 0);
      cfg_write(5, 3, 1, 1);
      e = edge_cnt + 1;
      enable[0] = 1'b1; enable[1] = 1'b1; enable[4] = 1'b1;
      $display("start edge=%0d ch=0,1,4", e);
      push(e, 0, 1'b0, 1'b1, 1'b0, 7);
      push(e, 4, 1'b0, 1'b1, 1'b0, 7);
      push(e, 1, 1'b0, 1'b1, 1'b0, 7);
      exp_run(0, e, 0, 23, 20, 10, 7);
      exp_run(4, e, 0, 23, 20, 10, 7);
      exp_run(1, e, 0, 8, 5, 2, 7);
      push(e + 10, 1, 1'b0, 1'b0, 1'b1, 7);
      exp_idle(1, e + 11, e + 55, 7);
      exp_idle(3, e, e + 55, 7);
      tick(5);
      start_ch(2, 7, e2);
      exp_run(2, e2, 0, 18, 7, 3, 7);
      tick(20);
      s = edge_cnt + 1;
      exp_run(0, e, 24, 24, 20, 10, 7);
      exp_run(4, e, 24, 24, 20, 10, 7);
      exp_run(2, e2, 19, 19, 7, 3, 7);
      exp_run(0, s, 0, 29, 20, 10, 7);
      exp_run(4, s, 0, 29, 20, 10, 7);
      exp_run(2, s, 0, 29, 7, 3, 7);
      sync_start = 1'b1;
      $display("sync  edge=%0d", s);
      tick(1);
      sync_start = 1'b0;
      tick(30);
      stop_ch(0, 7); stop_ch(1, 7); stop_ch(2, 7); stop_ch(4, 7);
      tick(2);

      // Enable dropped mid-burst: no burst_done afterwards
      cfg_write(1, 5, 2, 3);
      start_ch(1, 8, e);
      exp_run(1, e, 0, 6, 5, 2, 8);
      tick(8);
      enable[1] = 1'b0;
      $display("stop  edge=%0d ch=1", edge_cnt + 1);
      exp_idle(1, e + 8, e + 20, 8);
      tick(14);

      // Asynchronous reset while high; shadow returns to defaults
      cfg_write(0, 6, 3, 0);
      start_ch(0, 9, e);
      exp_run(0, e, 0, 0, 6, 3, 9);
      tick(3);
      k = edge_cnt;
      for (int ch = 0; ch < NUM_CH; ch++) exp_idle(ch, k, k + 2, 9);
      rst_n = 1'b0;
      $display("reset asserted after edge=%0d", k);
      tick(2);
      rst_n = 1'b1;
      push(k + 3, 0, 1'b0, 1'b1, 1'b0, 9);
      exp_run(0, k + 3, 0, 24, 20, 10, 9);
      tick(26);
      stop_ch(0, 9);
      tick(2);

      checks++;
      if (pulse_out !== '0) begin
         errors++;
         $display("FAIL final_idle pulse_out got=%b required=0", pulse_out);
      end
      checks++;
      if (active !== '0) begin
         errors++;
         $display("FAIL final_idle active got=%b required=0", active);
      end
      checks++;
      if (burst_done !== '0) begin
         errors++;
         $display("FAIL final_idle burst_done got=%b required=0", burst_done);
      end

      @(negedge clk);
      #1;
      foreach (sb[i]) begin
         checks++;
         errors++;
         $display("FAIL unchecked test=%0d cyc=%0d ch=%0d got=none required=%b%b%b",
                  sb[i].tid, sb[i].cyc, sb[i].ch, sb[i].p, sb[i].a, sb[i].d);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
